// File: rtl/gshare_btb_pkg.sv
// gshare_btb_pkg: counter encodings, FSM states and default sizes shared by the gshare_btb block
package gshare_btb_pkg;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam int DEF_PC_W = 16;
  localparam int DEF_IDX_W = 6;
  localparam int DEF_HIST_W = 6;
endpackage

// File: rtl/gshare_btb_if.sv
// gshare_btb_if: lookup and resolved-branch update bundle between the fetch side (master) and the predictor (slave)
interface gshare_btb_if import gshare_btb_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
);
  logic [PC_W-1:0] lk_pc, pred_target, upd_pc, upd_target;
  logic [IDX_W-1:0] pred_index, upd_index;
  logic pred_taken, ready, upd_valid, upd_taken, upd_pred_taken;
  logic [15:0] mispred_cnt;
  modport master(
    output lk_pc, upd_valid, upd_pc, upd_target, upd_index, upd_taken, upd_pred_taken,
    input pred_taken, pred_target, pred_index, ready, mispred_cnt
  );
  modport slave(
    input lk_pc, upd_valid, upd_pc, upd_target, upd_index, upd_taken, upd_pred_taken,
    output pred_taken, pred_target, pred_index, ready, mispred_cnt
  );
endinterface

// File: rtl/gshare_btb_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating branch counter
module sat_counter2 import gshare_btb_pkg::*; (
  input ctr_t cur,
  input logic inc,
  output ctr_t nxt
);
  always_comb nxt = inc ? (cur == ST ? ST : ctr_t'(cur + 2'd1)) : (cur == SNT ? SNT : ctr_t'(cur - 2'd1));
endmodule

// File: rtl/gshare_btb.sv
// gshare_btb: direct-mapped BTB with 2-bit counters; define GSHARE_HIST_EN to XOR global history into the index,
// otherwise it indexes bimodally by PC low bits.
module gshare_btb import gshare_btb_pkg::*; #(
  parameter int PC_W = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int HIST_W = DEF_HIST_W
) (
  input logic Clk,
  input logic Reset,
  gshare_btb_if.slave bus
);
  localparam int N = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  logic vld [N];
  logic [TAG_W-1:0] tag [N];
  logic [PC_W-1:0] tgt [N];
  ctr_t ctr [N];
  state_t state;
  logic [IDX_W-1:0] clrPtr, lkIdx;
  logic readyQ, updEn, updHit, lkHit, unused;
  logic [15:0] misCnt;
  ctr_t ctrNxt;
`ifdef GSHARE_HIST_EN
  logic [HIST_W-1:0] hist;
  always_ff @(posedge Clk)
    if (Reset) hist <= '0;
    else if (updEn) hist <= {hist[HIST_W-2:0], bus.upd_taken};
  assign lkIdx = bus.lk_pc[IDX_W-1:0] ^ IDX_W'(hist);
`else
  assign lkIdx = bus.lk_pc[IDX_W-1:0];
`endif
  // the update path is indexed by the returned lookup index, so the PC low bits are not needed here
  assign unused = ^bus.upd_pc[IDX_W-1:0];
  assign updEn = state == RUN && bus.upd_valid;
  assign updHit = vld[bus.upd_index] && tag[bus.upd_index] == bus.upd_pc[PC_W-1:IDX_W];
  assign lkHit = vld[lkIdx] && tag[lkIdx] == bus.lk_pc[PC_W-1:IDX_W];
  assign bus.pred_taken = readyQ && lkHit && ctr[lkIdx][1];
  assign bus.pred_target = bus.pred_taken ? tgt[lkIdx] : bus.lk_pc + 1'b1;
  assign bus.pred_index = lkIdx;
  assign bus.ready = readyQ;
  assign bus.mispred_cnt = misCnt;
  sat_counter2 satCtr (.cur(ctr[bus.upd_index]), .inc(bus.upd_taken), .nxt(ctrNxt));
  always_ff @(posedge Clk)
    if (state == INIT) begin
      vld[clrPtr] <= 1'b0;
      ctr[clrPtr] <= WNT;
      tgt[clrPtr] <= '0;
    end else if (updEn && (updHit || bus.upd_taken)) begin
      ctr[bus.upd_index] <= updHit ? ctrNxt : WT;
      if (bus.upd_taken) tgt[bus.upd_index] <= bus.upd_target;
      if (!updHit) begin
        vld[bus.upd_index] <= 1'b1;
        tag[bus.upd_index] <= bus.upd_pc[PC_W-1:IDX_W];
      end
    end
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= INIT;
      clrPtr <= '0;
      readyQ <= 1'b0;
      misCnt <= '0;
    end else if (state == INIT) begin
      clrPtr <= clrPtr + 1'b1;
      if (&clrPtr) begin
        state <= RUN;
        readyQ <= 1'b1;
      end
    end else if (updEn && bus.upd_taken != bus.upd_pred_taken && !(&misCnt)) misCnt <= misCnt + 1'b1;
endmodule

// File: tb/tb_gshare_btb.sv
// tb_gshare_btb: directed checks of init sequencing, allocation, counter saturation, write timing,
// mispredict counting and reset restart for gshare_btb (default build; history index checked when GSHARE_HIST_EN is set).
module tb_gshare_btb;
  logic Clk, Reset;
  int checks = 0, errors = 0, n;
  gshare_btb_if bus ();
  gshare_btb dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic doReset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask
  task automatic waitReady(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 200) begin
      tick();
      bus.upd_valid = 1'b0;
      cnt++;
    end
  endtask
  task automatic setUpd(input logic [15:0] pc, input logic [5:0] idx, input logic [15:0] tg, input logic tk, input logic ptk);
    bus.upd_pc = pc;
    bus.upd_index = idx;
    bus.upd_target = tg;
    bus.upd_taken = tk;
    bus.upd_pred_taken = ptk;
  endtask
  task automatic upd(input logic [15:0] pc, input logic [5:0] idx, input logic [15:0] tg, input logic tk, input logic ptk);
    setUpd(pc, idx, tg, tk, ptk);
    bus.upd_valid = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
  endtask
  task automatic look(input logic [15:0] pc);
    bus.lk_pc = pc;
    #1;
  endtask
  initial begin
    Reset = 1'b1;
    bus.lk_pc = '0;
    bus.upd_valid = 1'b0;
    setUpd(16'h0, 6'h0, 16'h0, 1'b0, 1'b0);
    doReset();
    check("reset_ready", bus.ready, 0);
    check("reset_mispred", bus.mispred_cnt, 0);
    look(16'h1234);
    check("init_pred_taken", bus.pred_taken, 0);
    check("init_pred_target", bus.pred_target, 16'h1235);
    check("init_pred_index", bus.pred_index, 6'h34);
    setUpd(16'h0010, 6'h10, 16'h0040, 1'b1, 1'b0);
    bus.upd_valid = 1'b1;
    waitReady(n);
    check("init_cycles", n, 64);
    check("init_upd_ignored_cnt", bus.mispred_cnt, 0);
    look(16'h0010);
    check("init_upd_ignored_hit", bus.pred_taken, 0);
    upd(16'h0010, 6'h10, 16'h0040, 1'b1, 1'b0);
    look(16'h0010);
    check("alloc_taken", bus.pred_taken, 1);
    check("alloc_target", bus.pred_target, 16'h0040);
    check("alloc_index", bus.pred_index, 6'h10);
    look(16'h0050);
    check("tagmiss_taken", bus.pred_taken, 0);
    check("tagmiss_target", bus.pred_target, 16'h0051);
    check("tagmiss_index", bus.pred_index, 6'h10);
    check("mispred_1", bus.mispred_cnt, 1);
    repeat (4) upd(16'h0010, 6'h10, 16'h0040, 1'b1, 1'b1);
    check("mispred_match_held", bus.mispred_cnt, 1);
    upd(16'h0050, 6'h10, 16'h0099, 1'b0, 1'b1);
    look(16'h0050);
    check("miss_nt_no_alloc", bus.pred_taken, 0);
    upd(16'h0010, 6'h10, 16'h0099, 1'b0, 1'b1);
    look(16'h0010);
    check("sat_one_nt_taken", bus.pred_taken, 1);
    check("nt_keeps_target", bus.pred_target, 16'h0040);
    upd(16'h0010, 6'h10, 16'h0099, 1'b0, 1'b1);
    look(16'h0010);
    check("sat_two_nt_taken", bus.pred_taken, 0);
    check("sat_two_nt_target", bus.pred_target, 16'h0011);
    check("mispred_4", bus.mispred_cnt, 4);
    setUpd(16'h0010, 6'h10, 16'h0077, 1'b1, 1'b0);
    bus.upd_valid = 1'b1;
    #1;
    check("same_cycle_old_taken", bus.pred_taken, 0);
    check("same_cycle_old_target", bus.pred_target, 16'h0011);
    tick();
    bus.upd_valid = 1'b0;
    #1;
    check("next_cycle_new_taken", bus.pred_taken, 1);
    check("next_cycle_new_target", bus.pred_target, 16'h0077);
    check("mispred_5", bus.mispred_cnt, 5);
    setUpd(16'h003F, 6'h3F, 16'h0000, 1'b0, 1'b1);
    bus.upd_valid = 1'b1;
    repeat (65529) tick();
    check("mispred_fffe", bus.mispred_cnt, 16'hFFFE);
    tick();
    check("mispred_ffff", bus.mispred_cnt, 16'hFFFF);
    repeat (3) tick();
    check("mispred_hold", bus.mispred_cnt, 16'hFFFF);
    bus.upd_valid = 1'b0;
    doReset();
    check("run_reset_mispred", bus.mispred_cnt, 0);
    check("run_reset_ready", bus.ready, 0);
    waitReady(n);
    check("run_reset_cycles", n, 64);
    look(16'h0010);
    check("run_reset_cleared", bus.pred_taken, 0);
    doReset();
    repeat (10) tick();
    doReset();
    waitReady(n);
    check("init_reset_cycles", n, 64);
    repeat (3) upd(16'h0001, 6'h01, 16'h0005, 1'b1, 1'b1);
    look(16'h0010);
`ifdef GSHARE_HIST_EN
    check("hist_index", bus.pred_index, 6'h17);
`else
    check("bimodal_index", bus.pred_index, 6'h10);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
